// File: rtl/eth_fcs_inserter.sv
// eth_fcs_inserter: transmit-side frame sequencer for the simple GEMAC.
// Passes an outbound frame through and appends the 4-byte Ethernet FCS.
// Optional feature macro: ETH_FCS_PAD_EN.
// When ETH_FCS_PAD_EN is defined, frames shorter than MIN_LEN bytes are
// zero-padded up to MIN_LEN before the FCS is appended.
// Also contains the `crc` module: a byte-wide reflected CRC-32 register.

// Byte-wide Ethernet CRC-32 (reflected, poly 0xEDB88320, init all ones).
// crc_out presents the complemented CRC in wire order: [31:24] is the
// first FCS byte on the wire. match flags the good-frame residue after a
// whole frame including its FCS has been absorbed.
module crc (
    input  logic        clk,
    input  logic        clear,
    input  logic        calc,
    input  logic [7:0]  data,
    output logic [31:0] crc_out,
    output logic        match
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_inv_s;

    // Advance a reflected CRC-32 state by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in,
                                               input logic [7:0]  d_in);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d_in[i];
            c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0000_0000);
        end
        return c;
    endfunction

    // Next-state: clear has priority over calc; otherwise hold.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (calc) begin
            crc_d = crc32_byte(crc_q, data);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC state register.
    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc_inv_s = ~crc_q;
    assign crc_out   = {crc_inv_s[7:0], crc_inv_s[15:8],
                        crc_inv_s[23:16], crc_inv_s[31:24]};
    assign match     = (crc_q == 32'hDEBB_20E3);

endmodule

module eth_fcs_inserter #(
    parameter int unsigned MIN_LEN = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    localparam logic [1:0] ST_DATA = 2'd0;
`ifdef ETH_FCS_PAD_EN
    localparam logic [1:0] ST_PAD  = 2'd1;
`endif
    localparam logic [1:0] ST_FCS  = 2'd2;

    // MIN_LEN must fit the 6-bit length counter.
    if ((MIN_LEN < 1) || (MIN_LEN > 63)) begin : g_min_len_range
        $error("eth_fcs_inserter: MIN_LEN must be in 1..63");
    end

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [1:0]  fcs_idx_q;
    logic [1:0]  fcs_idx_d;
    logic        frame_end_s;
    logic        crc_calc_s;
    logic        crc_clear_s;
    logic [31:0] crc_out_s;
    logic        crc_match_s;

`ifdef ETH_FCS_PAD_EN
    localparam logic [6:0] MIN_LEN_L = 7'(MIN_LEN);
    logic [5:0] len_q;
    logic [5:0] len_d;
    logic [6:0] len_inc_s;

    // Widened increment so the compare against MIN_LEN never wraps.
    assign len_inc_s = {1'b0, len_q} + 7'd1;
`endif

    // Sequencer: output muxing, handshake and next-state decisions.
    always_comb begin
        state_d     = state_q;
        fcs_idx_d   = fcs_idx_q;
        frame_end_s = 1'b0;
        crc_calc_s  = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        out_last    = 1'b0;
`ifdef ETH_FCS_PAD_EN
        len_d       = len_q;
`endif
        case (state_q)
            ST_DATA: begin
                out_data   = in_data;
                out_valid  = in_valid;
                in_ready   = out_ready;
                crc_calc_s = in_valid & out_ready;
                if (in_valid && out_ready) begin
`ifdef ETH_FCS_PAD_EN
                    // Saturate at MIN_LEN so long frames never wrap.
                    if (len_inc_s <= MIN_LEN_L) begin
                        len_d = len_inc_s[5:0];
                    end else begin
                        len_d = len_q;
                    end
                    if (in_last) begin
                        if (len_inc_s < MIN_LEN_L) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d   = ST_FCS;
                            fcs_idx_d = 2'd0;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
`else
                    if (in_last) begin
                        state_d   = ST_FCS;
                        fcs_idx_d = 2'd0;
                    end else begin
                        state_d = ST_DATA;
                    end
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef ETH_FCS_PAD_EN
            ST_PAD: begin
                out_valid  = 1'b1;
                out_data   = 8'h00;
                crc_calc_s = out_ready;
                if (out_ready) begin
                    len_d = len_inc_s[5:0];
                    if (len_inc_s == MIN_LEN_L) begin
                        state_d   = ST_FCS;
                        fcs_idx_d = 2'd0;
                    end else begin
                        state_d = ST_PAD;
                    end
                end else begin
                    state_d = ST_PAD;
                end
            end
`endif
            ST_FCS: begin
                out_valid = 1'b1;
                out_last  = (fcs_idx_q == 2'd3);
                case (fcs_idx_q)
                    2'd0:    out_data = crc_out_s[31:24];
                    2'd1:    out_data = crc_out_s[23:16];
                    2'd2:    out_data = crc_out_s[15:8];
                    2'd3:    out_data = crc_out_s[7:0];
                    default: out_data = 8'h00;
                endcase
                if (out_ready) begin
                    if (fcs_idx_q == 2'd3) begin
                        frame_end_s = 1'b1;
                        fcs_idx_d   = 2'd0;
                        state_d     = ST_DATA;
`ifdef ETH_FCS_PAD_EN
                        len_d       = 6'd0;
`endif
                    end else begin
                        fcs_idx_d = fcs_idx_q + 2'd1;
                        state_d   = ST_FCS;
                    end
                end else begin
                    state_d = ST_FCS;
                end
            end
            default: begin
                state_d   = ST_DATA;
                fcs_idx_d = 2'd0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_DATA;
            fcs_idx_q <= 2'd0;
`ifdef ETH_FCS_PAD_EN
            len_q     <= 6'd0;
`endif
        end else begin
            state_q   <= state_d;
            fcs_idx_q <= fcs_idx_d;
`ifdef ETH_FCS_PAD_EN
            len_q     <= len_d;
`endif
        end
    end

    // Clearing at frame-end readies the CRC for the next frame's first byte.
    assign crc_clear_s = reset | frame_end_s;

    crc u_crc (
        .clk     (clk),
        .clear   (crc_clear_s),
        .calc    (crc_calc_s),
        .data    (out_data),
        .crc_out (crc_out_s),
        .match   (crc_match_s)
    );

    // The good-frame residue flag is only meaningful on a receive path.
    logic unused_s;
    assign unused_s = crc_match_s;

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// Directed testbench for eth_fcs_inserter (works with or without ETH_FCS_PAD_EN).
module tb_eth_fcs_inserter;

    typedef logic [7:0] bq_t[$];

`ifdef ETH_FCS_PAD_EN
    localparam int PAD_TO = 60;
`else
    localparam int PAD_TO = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    logic        ref_clear;
    logic        ref_calc;
    logic [7:0]  ref_data;
    logic [31:0] ref_crc_out;
    logic        ref_match;

    int n_cmp = 0;
    int n_bad = 0;

    bq_t out_q;
    bq_t last_q;

    eth_fcs_inserter #(.MIN_LEN(60)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    crc u_ref (
        .clk     (clk),
        .clear   (ref_clear),
        .calc    (ref_calc),
        .data    (ref_data),
        .crc_out (ref_crc_out),
        .match   (ref_match)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Standard Ethernet CRC-32 of a byte sequence (final, complemented value).
    function automatic logic [31:0] model_crc(input bq_t fr);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (fr[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ fr[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                 c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // Expected output stream: payload, optional zero pad, FCS LSB-first.
    function automatic void build_expected(input bq_t fr, output bq_t ex);
        logic [31:0] f;
        ex = fr;
        while (ex.size() < PAD_TO) ex.push_back(8'h00);
        f = model_crc(ex);
        ex.push_back(f[7:0]);
        ex.push_back(f[15:8]);
        ex.push_back(f[23:16]);
        ex.push_back(f[31:24]);
    endfunction

    // Drive one frame and collect output transfers until out_last.
    task automatic run_frame(input bq_t fr, input bit rnd);
        int idx = 0;
        int cyc = 0;
        bit done = 1'b0;
        bit stall = 1'b0;
        logic [7:0] sd = 8'h00;
        logic sl = 1'b0;
        out_q.delete();
        last_q.delete();
        in_valid  = 1'b1;
        in_data   = fr[0];
        in_last   = (fr.size() == 1);
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            if (stall) begin
                check("stall_data", 32'(out_data), 32'(sd));
                check("stall_last", 32'(out_last), 32'(sl));
            end
            stall = out_valid && !out_ready;
            sd = out_data;
            sl = out_last;
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                last_q.push_back({7'd0, out_last});
                if (out_last) done = 1'b1;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            cyc++;
            in_valid  = (idx < fr.size());
            in_data   = (idx < fr.size()) ? fr[idx] : 8'h00;
            in_last   = (idx == fr.size() - 1);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("frame_done", 32'(done), 32'd1);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic compare_stream(input string tag, input bq_t got, input bq_t gl, input bq_t exp);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            check({tag, "_byte"}, 32'(got[i]), 32'(exp[i]));
            check({tag, "_last"}, 32'(gl[i]), (i == exp.size() - 1) ? 32'd1 : 32'd0);
        end
    endtask

    // Feed a whole output stream into the reference CRC and expect the residue.
    task automatic ref_check(input string tag, input bq_t q);
        ref_clear = 1'b1;
        ref_calc  = 1'b0;
        @(posedge clk);
        #1;
        ref_clear = 1'b0;
        foreach (q[i]) begin
            ref_calc = 1'b1;
            ref_data = q[i];
            @(posedge clk);
            #1;
        end
        ref_calc = 1'b0;
        check(tag, 32'(ref_match), 32'd1);
    endtask

    task automatic check_tail_123(input string tag, input bq_t got);
`ifndef ETH_FCS_PAD_EN
        check({tag, "_len13"}, 32'(got.size()), 32'd13);
        if (got.size() == 13) begin
            check({tag, "_fcs0"}, 32'(got[9]),  32'h26);
            check({tag, "_fcs1"}, 32'(got[10]), 32'h39);
            check({tag, "_fcs2"}, 32'(got[11]), 32'hF4);
            check({tag, "_fcs3"}, 32'(got[12]), 32'hCB);
        end
`else
        check({tag, "_len64"}, 32'(got.size()), 32'd64);
`endif
    endtask

    initial begin : main
        bq_t s123;
        bq_t e123;
        bq_t run1_q;
        bq_t run1_l;
        bq_t big;
        bq_t ebig;
        bq_t fa;
        bq_t f5;
        bq_t ea;
        bq_t e5;
        bq_t a_q;
        bq_t a_l;
        bit saw_last;

        s123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        build_expected(s123, e123);

        reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        ref_clear = 1'b1; ref_calc = 1'b0; ref_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: pass-through, CRC preset, no transfer across an edge.
        check("rst_crc", dut.u_crc.crc_q, 32'hFFFF_FFFF);
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd1);
        check("rst_out_data", 32'(out_data), 32'hA5);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_last", 32'(out_last), 32'd0);
        out_ready = 1'b0;
        #1;
        check("rst_in_ready_bp", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #1;
        check("rst_out_valid_idle", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // "123456789" with out_ready held high.
        run_frame(s123, 1'b0);
        run1_q = out_q;
        run1_l = last_q;
        compare_stream("s123", run1_q, run1_l, e123);
        check_tail_123("s123", run1_q);
        ref_check("s123_ref_match", run1_q);

        // Same frame with random backpressure must give the identical stream.
        run_frame(s123, 1'b1);
        compare_stream("s123_rnd", out_q, last_q, run1_q);

        // 100-byte frame: never padded.
        for (int i = 0; i < 100; i++) big.push_back(8'($urandom));
        build_expected(big, ebig);
        run_frame(big, 1'b0);
        check("big_len104", 32'(out_q.size()), 32'd104);
        compare_stream("big", out_q, last_q, ebig);
        ref_check("big_ref_match", out_q);

        // Back-to-back single-byte frames.
        fa = '{8'hAA};
        f5 = '{8'h55};
        build_expected(fa, ea);
        build_expected(f5, e5);
        run_frame(fa, 1'b0);
        a_q = out_q;
        a_l = last_q;
        run_frame(f5, 1'b0);
        compare_stream("b2b_aa", a_q, a_l, ea);
        compare_stream("b2b_55", out_q, last_q, e5);

        // Reset mid-frame after 5 payload bytes.
        saw_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hC0 + i); in_last = 1'b0;
            @(negedge clk);
            if (out_valid && out_last) saw_last = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_no_last", 32'(saw_last), 32'd0);
        check("abort_crc", dut.u_crc.crc_q, 32'hFFFF_FFFF);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        run_frame(s123, 1'b0);
        compare_stream("after_abort", out_q, last_q, e123);
        check_tail_123("after_abort", out_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
